// File: rtl/sync_fifo_mem_pipe.sv
// Simple dual-port RAM for the sync FIFO family: byte-lane write mask,
// registered read (1 or 2 cycles), read-valid pipe, collision bypass.
// Ports: clk, reset_n (sync, active-low); wr_en/wr_addr/wr_data/wr_be/
// wr_par_inj write side; rd_en/rd_addr read request; rd_data/rd_valid/
// rd_par_err read result. Optional lane parity: SYNC_FIFO_MEM_PARITY_EN.
module sync_fifo_mem_pipe #(
  parameter int MEM_DEPTH  = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int RD_LATENCY = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic                  wr_par_inj,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_par_err
);

  localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L =
    (ADDR_WIDTH+1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  wr_ok;
  logic                  rd_ok;
  logic                  byp_hit;
  logic [DATA_WIDTH-1:0] bmask;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] rd_word_d;
  logic                  rd_err_d;

  // Depth need not be a power of two, so range-check both ports.
  assign wr_ok   = wr_en && ({1'b0, wr_addr} < DEPTH_L);
  assign rd_ok   = {1'b0, rd_addr} < DEPTH_L;
  assign byp_hit = (BYPASS != 0) && wr_ok && rd_en &&
                   (wr_addr == rd_addr);

  always_comb begin
    bmask = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      bmask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{wr_be[i]}};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_addr] <= (mem_q[wr_addr] & ~bmask) |
                        (wr_data & bmask);
    end
  end

  always_comb begin
    old_word  = rd_ok ? mem_q[rd_addr] : '0;
    rd_word_d = old_word;
    if (byp_hit) begin
      rd_word_d = (old_word & ~bmask) | (wr_data & bmask);
    end
  end

`ifdef SYNC_FIFO_MEM_PARITY_EN
  logic [NUM_LANES-1:0] par_q [MEM_DEPTH];
  logic [NUM_LANES-1:0] wr_par;
  logic [NUM_LANES-1:0] old_par;
  logic [NUM_LANES-1:0] rd_par;
  logic [NUM_LANES-1:0] calc_par;

  always_comb begin
    wr_par = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      wr_par[i] = (^wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]) ^ wr_par_inj;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      par_q[wr_addr] <= (par_q[wr_addr] & ~wr_be) |
                        (wr_par & wr_be);
    end
  end

  always_comb begin
    old_par  = rd_ok ? par_q[rd_addr] : '0;
    rd_par   = byp_hit ? ((old_par & ~wr_be) | (wr_par & wr_be))
                       : old_par;
    calc_par = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      calc_par[i] = ^rd_word_d[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    rd_err_d = rd_ok && (|(calc_par ^ rd_par));
  end
`else
  logic unused_par_inj;
  assign unused_par_inj = wr_par_inj;
  assign rd_err_d       = 1'b0;
`endif

  logic                  s1_v_q;
  logic [DATA_WIDTH-1:0] s1_d_q;
  logic                  s1_e_q;

  // Data holds when no read is issued; error is qualified by valid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_v_q <= 1'b0;
      s1_d_q <= '0;
      s1_e_q <= 1'b0;
    end else begin
      s1_v_q <= rd_en;
      s1_e_q <= rd_en & rd_err_d;
      if (rd_en) begin
        s1_d_q <= rd_word_d;
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  s2_v_q;
      logic [DATA_WIDTH-1:0] s2_d_q;
      logic                  s2_e_q;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          s2_v_q <= 1'b0;
          s2_d_q <= '0;
          s2_e_q <= 1'b0;
        end else begin
          s2_v_q <= s1_v_q;
          s2_e_q <= s1_e_q;
          if (s1_v_q) begin
            s2_d_q <= s1_d_q;
          end
        end
      end

      assign rd_valid   = s2_v_q;
      assign rd_data    = s2_d_q;
      assign rd_par_err = s2_e_q;
    end else begin : g_lat1
      assign rd_valid   = s1_v_q;
      assign rd_data    = s1_d_q;
      assign rd_par_err = s1_e_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_mem_pipe.sv
// Bench for sync_fifo_mem_pipe: two instances (latency 1 / bypass,
// latency 2 / no bypass / depth 12) against an array-based model.
module tb_sync_fifo_mem_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        wr_par_inj;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data1, rd_data2;
  logic        rd_valid1, rd_valid2;
  logic        rd_par_err1, rd_par_err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_mem_pipe #(
    .MEM_DEPTH(16), .RD_LATENCY(1), .BYPASS(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .wr_par_inj(wr_par_inj),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1),
    .rd_par_err(rd_par_err1)
  );

  sync_fifo_mem_pipe #(
    .MEM_DEPTH(12), .RD_LATENCY(2), .BYPASS(0)
  ) dut2 (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .wr_par_inj(wr_par_inj),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data2), .rd_valid(rd_valid2),
    .rd_par_err(rd_par_err2)
  );

  // Model: per-instance word store plus a per-lane "parity flipped" flag.
  int          depth [2] = '{16, 12};
  bit          byp   [2] = '{1'b1, 1'b0};
  logic [31:0] mm    [2][16];
  logic [3:0]  mf    [2][16];
  logic [31:0] lastd [2];
  bit          pv;
  logic [31:0] pd;
  bit          pe;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lmask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

  task automatic cyc(input bit rn, input bit we, input logic [3:0] wa,
                     input logic [31:0] wd, input logic [3:0] be,
                     input bit inj, input bit re,
                     input logic [3:0] ra);
    logic [31:0] ed [2];
    bit          ee [2];
    logic [31:0] m;
    logic [3:0]  fl;
    bit          v1, v2, e1, e2;
    logic [31:0] d1, d2;
    reset_n = rn; wr_en = we; wr_addr = wa; wr_data = wd;
    wr_be = be; wr_par_inj = inj; rd_en = re; rd_addr = ra;
    @(posedge clk);
    m = lmask(be);
    for (int k = 0; k < 2; k++) begin
      ed[k] = '0; ee[k] = 1'b0;
      if (int'(ra) < depth[k]) begin
        ed[k] = mm[k][ra];
        fl    = mf[k][ra];
        if (byp[k] && we && wa == ra) begin
          ed[k] = (ed[k] & ~m) | (wd & m);
          fl    = (fl & ~be) | ({4{inj}} & be);
        end
`ifdef SYNC_FIFO_MEM_PARITY_EN
        ee[k] = |fl;
`else
        ee[k] = (fl == 4'hF) & 1'b0;
`endif
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (we && int'(wa) < depth[k]) begin
        mm[k][wa] = (mm[k][wa] & ~m) | (wd & m);
        mf[k][wa] = (mf[k][wa] & ~be) | ({4{inj}} & be);
      end
    end
    if (!rn) begin
      v1 = 0; v2 = 0; e1 = 0; e2 = 0;
      lastd[0] = '0; lastd[1] = '0; pv = 0;
    end else begin
      v1 = re;
      if (re) lastd[0] = ed[0];
      e1 = re & ee[0];
      v2 = pv;
      if (pv) lastd[1] = pd;
      e2 = pv & pe;
      pv = re; pd = ed[1]; pe = ee[1];
    end
    d1 = lastd[0]; d2 = lastd[1];
    #1;
    chk("d1.valid", 32'(rd_valid1), 32'(v1));
    chk("d1.data", rd_data1, d1);
    chk("d1.perr", 32'(rd_par_err1), 32'(e1));
    chk("d2.valid", 32'(rd_valid2), 32'(v2));
    chk("d2.data", rd_data2, d2);
    chk("d2.perr", 32'(rd_par_err2), 32'(e2));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    pv = 0; pd = '0; pe = 0;
    lastd[0] = '0; lastd[1] = '0;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 16; a++) begin
        mm[k][a] = 'x; mf[k][a] = 'x;
      end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // Clear all words so later reads are well defined.
    for (int a = 0; a < 16; a++)
      cyc(1, 1, 4'(a), 32'h0, 4'hF, 0, 0, 0);
    idle(2);
    // Full write then read back.
    cyc(1, 1, 3, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 3);
    idle(3);
    // Lane-masked overwrite.
    cyc(1, 1, 5, 32'h11223344, 4'hF, 0, 0, 0);
    cyc(1, 1, 5, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    cyc(1, 1, 5, 32'hFFFFFFFF, 4'b0000, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 5);
    idle(3);
    // Same-edge collision, then plain re-read.
    cyc(1, 1, 7, 32'hCAFEF00D, 4'hF, 0, 1, 7);
    cyc(1, 0, 0, 0, 0, 0, 1, 7);
    idle(3);
    // Partial collision.
    cyc(1, 1, 3, 32'h01020304, 4'b1001, 0, 1, 3);
    idle(3);
    // Back-to-back reads across the whole address range.
    for (int a = 0; a < 16; a++)
      cyc(1, 0, 0, 0, 0, 0, 1, 4'(a));
    idle(3);
    // Out-of-range write on the 12-deep instance.
    cyc(1, 1, 13, 32'h5A5A5A5A, 4'hF, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 13);
    idle(3);
    // Reset while reads are in flight.
    cyc(1, 0, 0, 0, 0, 0, 1, 9);
    cyc(0, 0, 0, 0, 0, 0, 1, 9);
    idle(3);
    cyc(1, 0, 0, 0, 0, 0, 1, 9);
    idle(3);
    // Parity inject, then clean rewrite.
    cyc(1, 1, 2, 32'h12345678, 4'hF, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 2);
    idle(3);
    cyc(1, 1, 2, 32'h12345678, 4'hF, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 2);
    cyc(1, 1, 4, 32'h0F0F0F0F, 4'b0011, 1, 1, 4);
    idle(3);
    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] wa, ra;
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 1) == 0) ? wa : 4'($urandom_range(0, 15));
      cyc($urandom_range(0, 39) != 0, 1'($urandom), wa, $urandom,
          4'($urandom), $urandom_range(0, 7) == 0, 1'($urandom), ra);
    end
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
